// File: rtl/phase_seq_ctrl.sv
// phase_seq_ctrl: start/abort-gated sequencer for the 4-phase generator.
// On an accepted start it walks the phase code 000->001->010->011. Each phase
// is held for a captured dwell count, and the whole pass repeats for a
// captured loop count. A one-cycle done pulse follows a normal finish, and a
// one-cycle aborted pulse follows an accepted abort.
//
// Control sampling: start is a level that is sampled only while IDLE, and it
// is not queued. abort is sampled only while RUN and overrides every RUN
// update. Neither input has a ready/acknowledge; busy is the indication that
// a start has been taken.
module phase_seq_ctrl #(
  parameter int DWELL_W = 4,
  parameter int LOOP_W  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [LOOP_W-1:0]  loops,
  output logic [2:0]         phase,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [LOOP_W-1:0]  loop_idx,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DONE  = 2'd2,
    S_ABORT = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [LOOP_W-1:0]    loops_q, loops_d;
  logic [DWELL_W-1:0]   dwell_cnt_q, dwell_cnt_d;
  logic [1:0]           phase_q, phase_d;
  logic [LOOP_W-1:0]    loop_cnt_q, loop_cnt_d;

  // State and counter registers, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      dwell_q     <= '0;
      loops_q     <= '0;
      dwell_cnt_q <= '0;
      phase_q     <= '0;
      loop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      loops_q     <= loops_d;
      dwell_cnt_q <= dwell_cnt_d;
      phase_q     <= phase_d;
      loop_cnt_q  <= loop_cnt_d;
    end
  end

  // Next-state and counter update. Captured operands are never zero, so the
  // "minus one" terminal compares cannot underflow.
  always_comb begin
    state_d     = state_q;
    dwell_d     = dwell_q;
    loops_d     = loops_q;
    dwell_cnt_d = dwell_cnt_q;
    phase_d     = phase_q;
    loop_cnt_d  = loop_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dwell_d     = (dwell == '0) ? DWELL_W'(1) : dwell;
          loops_d     = (loops == '0) ? LOOP_W'(1) : loops;
          dwell_cnt_d = '0;
          phase_d     = '0;
          loop_cnt_d  = '0;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_ABORT;
        end else if (dwell_cnt_q == dwell_q - DWELL_W'(1)) begin
          dwell_cnt_d = '0;
          phase_d     = phase_q + 2'd1;
          if (phase_q == 2'd3) begin
            if (loop_cnt_q == loops_q - LOOP_W'(1)) begin
              state_d = S_DONE;
            end else begin
              loop_cnt_d = loop_cnt_q + LOOP_W'(1);
            end
          end
        end else begin
          dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore output decode from the registered state and counters.
  always_comb begin
    phase    = 3'b000;
    busy     = 1'b0;
    done     = 1'b0;
    aborted  = 1'b0;
    loop_idx = '0;
    case (state_q)
      S_RUN: begin
        busy     = 1'b1;
        phase    = {1'b0, phase_q};
        loop_idx = loop_cnt_q;
      end
      S_DONE:  done    = 1'b1;
      S_ABORT: aborted = 1'b1;
      default: ;
    endcase
  end

  assign state_dbg = state_q;

endmodule
